ifm_sparsemap_walker: RTL and testbench

- Sequencer that drives the IFM input-select datapath: issues chunk start, walks every sparsemap word of a chunk, and emits one priority-encoder match index per set bit.
- Pulses end-of-word so the datapath base address advances by the word's popcount.
- Sits between the chunk-level controller (start/done) and the IFM input-select/prefix-sum datapath; downstream MAC consumes matches via valid/ready.

---
 rtl/ifm_pkg.sv | 35 +++
 rtl/ifm_lsb_pri_enc.sv | 25 ++
 rtl/ifm_sparsemap_walker.sv | 126 ++++++++++++
 tb/tb_ifm_sparsemap_walker.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ifm_pkg.sv
// Shared types and default sizing for the IFM sparsemap walkers.
// Pure declarations, no latency.
// No flow control; consumers size their ports from these values.
`ifndef PREFIX_SUM_SIZE
`define PREFIX_SUM_SIZE 8
`endif
`ifndef MEM_SIZE
`define MEM_SIZE 64
`endif

package ifm_pkg;

    // Build-time defaults, overridable through the compile-time macros above
    localparam int PSUM_SIZE_DEF = `PREFIX_SUM_SIZE;
    localparam int MEM_SIZE_DEF  = `MEM_SIZE;
    localparam int SMAP_NUM_DEF  = MEM_SIZE_DEF / PSUM_SIZE_DEF;

    // Index width that stays legal (>=1 bit) even for a single-entry range
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Default widths of word index, match index and accepted-match count
    localparam int WORD_IDX_W  = idx_w(SMAP_NUM_DEF);
    localparam int MATCH_IDX_W = idx_w(PSUM_SIZE_DEF);
    localparam int CNT_W       = $clog2(MEM_SIZE_DEF) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/ifm_lsb_pri_enc.sv
// Lowest-set-bit priority encoder over one sparsemap word.
// Purely combinational, zero latency.
// No backpressure; o_any=0 means the index is meaningless (driven 0).
module ifm_lsb_pri_enc #(
    parameter  int WIDTH = 8,
    localparam int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] i_word,
    output logic [IW-1:0]    o_idx,
    output logic             o_any
);

    // Scan from MSB down so the last hit written is the lowest set bit
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_word[i]) begin
                o_idx = IW'(i);
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ifm_sparsemap_walker.sv
// Walks every sparsemap word of an IFM chunk, one match index per set bit.
// First match valid 2 cycles after start_i; end/valid combinational in SCAN.
// match_ready_i low holds index and mask; the walk simply stalls.
module ifm_sparsemap_walker
    import ifm_pkg::*;
#(
    parameter  int PREFIX_SUM_SIZE = PSUM_SIZE_DEF,
    parameter  int MEM_SIZE        = MEM_SIZE_DEF,
    localparam int SPARSEMAP_NUM   = MEM_SIZE / PREFIX_SUM_SIZE,
    localparam int AW              = idx_w(SPARSEMAP_NUM),
    localparam int IW              = idx_w(PREFIX_SUM_SIZE),
    localparam int CW              = $clog2(MEM_SIZE) + 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic [AW-1:0]              rd_sparsemap_last_i,
    input  logic [PREFIX_SUM_SIZE-1:0] rd_sparsemap_i,
    output logic [AW-1:0]              rd_sparsemap_addr_o,
    output logic                       chunk_start_o,
    output logic [IW-1:0]              pri_enc_match_addr_o,
    output logic                       match_valid_o,
    input  logic                       match_ready_i,
    output logic                       pri_enc_end_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [CW-1:0]              nz_count_o
);

    localparam logic [AW-1:0]              ADDR_ONE = AW'(1);
    localparam logic [PREFIX_SUM_SIZE-1:0] MASK_ONE = PREFIX_SUM_SIZE'(1);
    localparam logic [CW-1:0]              NZ_ONE   = CW'(1);
    localparam logic [CW-1:0]              NZ_MAX   = CW'(MEM_SIZE);

    state_t                     r_state;
    logic [AW-1:0]              r_addr;
    logic [PREFIX_SUM_SIZE-1:0] r_mask;
    logic [CW-1:0]              r_nz;

    logic [IW-1:0]              w_idx;
    logic                       w_any;
    logic [PREFIX_SUM_SIZE-1:0] w_mask_clr;
    logic                       w_in_scan;
    logic                       w_accept;
    logic                       w_last_word;

    ifm_lsb_pri_enc #(
        .WIDTH (PREFIX_SUM_SIZE)
    ) u_pri_enc (
        .i_word (r_mask),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    // Abort kills the scan cycle outright, so no handshake or end can slip through
    assign w_in_scan   = (r_state == SCAN) && !abort_i;
    assign w_mask_clr  = r_mask & (r_mask - MASK_ONE);
    assign w_accept    = match_valid_o && match_ready_i;
    assign w_last_word = (r_addr == rd_sparsemap_last_i);

    // End fires on an empty word, or together with acceptance of the last set bit
    assign match_valid_o        = w_in_scan && w_any;
    assign pri_enc_end_o        = w_in_scan && (!w_any || (w_accept && (w_mask_clr == '0)));
    assign pri_enc_match_addr_o = w_idx;

    // Mealy start pulse; gated by reset so a held start_i cannot leak through
    assign chunk_start_o        = !rst_i && (r_state == IDLE) && start_i && !abort_i;
    assign done_o               = (r_state == DONE) && !abort_i;
    assign busy_o               = (r_state != IDLE);
    assign rd_sparsemap_addr_o  = r_addr;
    assign nz_count_o           = r_nz;

    // Walk sequencer: word address, remaining-bit mask and accepted-match count
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_mask  <= '0;
            r_nz    <= '0;
        end else if (abort_i) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_mask  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_state <= LOAD;
                        r_addr  <= '0;
                        r_nz    <= '0;
                    end
                end
                LOAD: begin
                    r_mask  <= rd_sparsemap_i;
                    r_state <= SCAN;
                end
                SCAN: begin
                    if (w_accept) begin
                        r_mask <= w_mask_clr;
                        if (r_nz != NZ_MAX) begin
                            r_nz <= r_nz + NZ_ONE;
                        end
                    end
                    // Address only moves after the end cycle so the datapath sees it stable
                    if (pri_enc_end_o) begin
                        if (w_last_word) begin
                            r_addr  <= '0;
                            r_state <= DONE;
                        end else begin
                            r_addr  <= r_addr + ADDR_ONE;
                            r_state <= LOAD;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifm_sparsemap_walker.sv
// Self-checking bench for ifm_sparsemap_walker (PREFIX_SUM_SIZE=8, MEM_SIZE=64).
// Expected match order is derived from the words' set bits; timing from popcounts.
// Ready is driven constant, toggling or random to exercise stalls.
module tb_ifm_sparsemap_walker;

    localparam int PSS = 8;
    localparam int MEM = 64;
    localparam int NW  = MEM / PSS;
    localparam int AW  = 3;
    localparam int IW  = 3;
    localparam int CW  = 7;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           abort;
    logic           ready;
    logic [AW-1:0]  last;
    logic [PSS-1:0] rd_word;
    logic [AW-1:0]  addr;
    logic           chunk_start_o;
    logic [IW-1:0]  idx;
    logic           match_valid_o;
    logic           pri_enc_end_o;
    logic           busy_o;
    logic           done_o;
    logic [CW-1:0]  nz;

    logic [PSS-1:0] mem [NW];

    int checks   = 0;
    int failures = 0;
    int scan_cycles;
    bit ab;

    always #5 clk = ~clk;

    assign rd_word = mem[addr];

    ifm_sparsemap_walker #(
        .PREFIX_SUM_SIZE (PSS),
        .MEM_SIZE        (MEM)
    ) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .start_i              (start),
        .abort_i              (abort),
        .rd_sparsemap_last_i  (last),
        .rd_sparsemap_i       (rd_word),
        .rd_sparsemap_addr_o  (addr),
        .chunk_start_o        (chunk_start_o),
        .pri_enc_match_addr_o (idx),
        .match_valid_o        (match_valid_o),
        .match_ready_i        (ready),
        .pri_enc_end_o        (pri_enc_end_o),
        .busy_o               (busy_o),
        .done_o               (done_o),
        .nz_count_o           (nz)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  busy_o, 0);
        chk({tag, "_valid"}, match_valid_o, 0);
        chk({tag, "_end"},   pri_enc_end_o, 0);
        chk({tag, "_start"}, chunk_start_o, 0);
        chk({tag, "_done"},  done_o, 0);
        chk({tag, "_nz"},    nz, 0);
        chk({tag, "_addr"},  addr, 0);
        chk({tag, "_idx"},   idx, 0);
    endtask

    // One chunk walk, entered and left at posedge+1. Optionally aborts on (abort_w, abort_b).
    task automatic walk(input int lst, input int rmode, input bit poke,
                        input int abort_w, input int abort_b, output bit aborted);
        int qa[$];
        int qi[$];
        int total, cur, cyc, stalls, exp_cyc;
        bit fin;
        total = 0; cur = 0; cyc = 0; stalls = 0; exp_cyc = 1; fin = 0;
        aborted = 0;
        scan_cycles = 0;
        // Reference: every set bit in ascending word/bit order; one LOAD per word,
        // one SCAN cycle per set bit (at least one for an empty word), plus DONE.
        for (int w = 0; w <= lst; w++) begin
            int pop;
            pop = 0;
            for (int b = 0; b < PSS; b++) begin
                if (mem[w][b]) begin
                    qa.push_back(w);
                    qi.push_back(b);
                    pop++;
                end
            end
            total   += pop;
            exp_cyc += 1 + ((pop == 0) ? 1 : pop);
        end

        last  = AW'(lst);
        start = 1'b1;
        abort = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        chk("chunk_start", chunk_start_o, 1);
        chk("busy_in_idle", busy_o, 0);
        @(posedge clk); #1;

        while (!fin && cyc < 400) begin
            cyc++;
            ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? cyc[0] : ($urandom_range(3) != 0);
            start = poke;
            @(negedge clk);
            chk("no_chunk_start_busy", chunk_start_o, 0);
            if (abort_w >= 0 && match_valid_o && cur == abort_w &&
                qi.size() > 0 && qi[0] == abort_b) begin
                abort = 1'b1;
                #1;
                chk("abort_no_end", pri_enc_end_o, 0);
                chk("abort_no_done", done_o, 0);
                @(posedge clk); #1;
                abort = 1'b0;
                start = 1'b0;
                @(negedge clk);
                chk("abort_busy", busy_o, 0);
                chk("abort_done", done_o, 0);
                @(posedge clk); #1;
                aborted = 1;
                fin = 1;
            end else begin
                if (match_valid_o) begin
                    if (qa.size() == 0) begin
                        chk("spurious_valid", 1, 0);
                    end else begin
                        chk("match_addr", addr, qa[0]);
                        chk("match_idx", idx, qi[0]);
                        if (ready) begin
                            void'(qa.pop_front());
                            void'(qi.pop_front());
                        end else begin
                            stalls++;
                        end
                    end
                end
                if (match_valid_o || pri_enc_end_o) scan_cycles++;
                if (pri_enc_end_o) begin
                    chk("end_addr", addr, cur);
                    chk("end_word_drained", (qa.size() > 0 && qa[0] == cur), 0);
                    cur++;
                end
                if (done_o) begin
                    chk("done_words", cur, lst + 1);
                    chk("done_queue_empty", qa.size(), 0);
                    chk("done_nz_count", nz, total);
                    chk("done_cycle", cyc, exp_cyc + stalls);
                    chk("done_addr_zero", addr, 0);
                    fin = 1;
                end
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        if (!fin) begin
            chk("walk_timeout", 0, 1);
        end else if (!aborted) begin
            @(negedge clk);
            chk("idle_after_done", busy_o, 0);
            chk("nz_holds", nz, total);
            chk("done_one_cycle", done_o, 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        ready = 1'b0;
        last  = '0;
        for (int w = 0; w < NW; w++) mem[w] = '0;
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single word, matches 2,5,7
        mem[0] = 8'b1010_0100;
        walk(0, 0, 0, -1, 0, ab);

        // Empty / two-bit / empty words
        mem[0] = 8'h00; mem[1] = 8'h81; mem[2] = 8'h00;
        walk(2, 0, 0, -1, 0, ab);

        // Full word with ready toggling: 8 accepts + 8 stalls
        mem[0] = 8'hFF;
        walk(0, 1, 0, -1, 0, ab);
        chk("ff_scan_cycles", scan_cycles, 16);

        // Abort on word1 index 3, then a clean restart
        for (int w = 0; w < NW; w++) mem[w] = 8'($urandom);
        mem[1] = (mem[1] & 8'hF8) | 8'h08;
        walk(3, 0, 0, 1, 3, ab);
        chk("abort_taken", ab, 1);
        walk(3, 2, 0, -1, 0, ab);

        // start_i held high throughout the walk is ignored
        walk(4, 2, 1, -1, 0, ab);

        // Randomized chunks, including empty words and stalls
        for (int t = 0; t < 20; t++) begin
            for (int w = 0; w < NW; w++)
                mem[w] = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
            walk($urandom_range(NW - 1), 2, 0, -1, 0, ab);
        end

        // Full buffer of set bits reaches the count ceiling
        for (int w = 0; w < NW; w++) mem[w] = 8'hFF;
        walk(NW - 1, 0, 0, -1, 0, ab);

        // Asynchronous reset mid-SCAN
        mem[0] = 8'hFF;
        last   = '0;
        ready  = 1'b1;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_reset_valid", match_valid_o, 1);
        #2;
        rst   = 1'b1;
        start = 1'b1;
        #1;
        chk_all_zero("async_reset");
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_reset_idle", busy_o, 0);
            chk("post_reset_no_start", chunk_start_o, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
